// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - next-PC mode encoding shared by the PC unit files
package pc_unit_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] PCM_SEQ  = 3'd0;
    localparam logic [MODE_W-1:0] PCM_BR   = 3'd1;
    localparam logic [MODE_W-1:0] PCM_JMP  = 3'd2;
    localparam logic [MODE_W-1:0] PCM_CALL = 3'd3;
    localparam logic [MODE_W-1:0] PCM_RET  = 3'd4;
    localparam logic [MODE_W-1:0] PCM_TRAP = 3'd5;
    localparam logic [MODE_W-1:0] PCM_ERET = 3'd6;

endpackage

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - circular return-address stack, overwrites oldest entry when full
module pc_unit_ras #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          push_data,
    output logic [AW-1:0]          top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign top   = mem_q[top_q];
    assign count = count_q;

    // Pointer/count update; a push on a full stack wraps onto the oldest slot, a pop on empty does nothing
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push) begin
            top_d = top_q + PW'(1);
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[top_d] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered, stall-aware program counter with call/return stack and trap PC
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [AW-1:0] TRAP_VEC  = 'h10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [MODE_W-1:0]          mode,
    input  logic                       cond,
    input  logic [AW-1:0]              offset,
    input  logic [AW-1:0]              target,
    output logic [AW-1:0]              pc,
    output logic [AW-1:0]              pc_next,
    output logic [AW-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_uflow
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [AW-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc, ras_top;
    logic          uflow_q, uflow_d;
    logic          ras_push, ras_pop, ras_empty, ras_full;

    assign pc_inc = pc_q + AW'(1);

    // Next-PC mux; reserved mode falls through to sequential
    always_comb begin
        pc_d = pc_inc;
        case (mode)
            PCM_BR:   pc_d = cond ? (pc_inc + offset) : pc_inc;
            PCM_JMP:  pc_d = target;
            PCM_CALL: pc_d = target;
            PCM_RET:  pc_d = ras_empty ? pc_inc : ras_top;
            PCM_TRAP: pc_d = TRAP_VEC;
            PCM_ERET: pc_d = epc_q;
            default:  pc_d = pc_inc;
        endcase
    end

    // Side effects of the current mode, suppressed entirely while stalled
    always_comb begin
        epc_d    = epc_q;
        uflow_d  = uflow_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (en) begin
            case (mode)
                PCM_CALL: ras_push = 1'b1;
                PCM_RET: begin
                    ras_pop = 1'b1;
                    if (ras_empty) begin
                        uflow_d = 1'b1;
                    end
                end
                PCM_TRAP: epc_d = pc_q;
                default: ;
            endcase
        end
    end

    // PC, exception PC and sticky underflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            epc_q   <= RESET_PC;
            uflow_q <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            uflow_q <= uflow_d;
        end
    end

    pc_unit_ras #(
        .DEPTH (RAS_DEPTH),
        .AW    (AW)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Stack-full flag must agree with the entry count
    assert property (@(posedge clk) disable iff (!rst_n) ras_full == (ras_count == CW'(RAS_DEPTH)));

    assign pc        = pc_q;
    assign pc_next   = pc_d;
    assign epc       = epc_q;
    assign ras_uflow = uflow_q;

endmodule
